ulpi_tx_framer: RTL

- Downstream neighbour of the USB packet encoder.
- Consumes the encoder's AXI-Stream byte packets and drives the ULPI transmit protocol toward the PHY.
- The first byte of each packet is the PID. It is sent as a ULPI TXCMD, the remaining bytes follow on NXT, and the packet is terminated with STP.
- Also detects PHY bus takeover (DIR), upstream underrun and bad PIDs, and drains or aborts cleanly in each case.

---
 rtl/ulpi_tx_framer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ulpi_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : ulpi_tx_framer
//  Description : Converts AXI-Stream byte packets from the USB packet encoder
//                into the ULPI link-side transmit protocol. The first byte
//                (PID) is sent as a TXCMD, payload bytes advance on NXT, and
//                the packet ends with a one-cycle STP. PHY bus takeover (DIR),
//                upstream underrun and malformed PIDs abort the packet and
//                drain the rest of it from upstream.
//  Ports       :
//    clock, reset        - 60 MHz ULPI clock, synchronous active-high reset
//    s_tvalid/s_tready/s_tlast/s_tdata - AXI-Stream byte input
//    ulpi_dir_i          - PHY owns the bus when high
//    ulpi_nxt_i          - PHY accepted the byte on ulpi_data_o
//    ulpi_stp_o          - ULPI STP (registered)
//    ulpi_data_o         - link-driven ULPI data (registered)
//    busy_o              - framer is not idle
//    done_o              - pulse, packet ended with a normal STP
//    err_o               - pulse, packet aborted / underrun / bad PID
//  Revision    : 1.0 - initial release
// ============================================================================
module ulpi_tx_framer #(
  parameter int TX_GAP   = 2,
  parameter int GAP_BITS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o,
  output logic [7:0] ulpi_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND  = 3'd1,
    S_STOP  = 3'd2,
    S_DRAIN = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [GAP_BITS-1:0] C_GAP_LOAD = GAP_BITS'(TX_GAP);

  state_t              state_q, state_d;
  logic [7:0]          data_q, data_d;
  logic                stp_q, stp_d;
  logic                last_q, last_d;      // byte on the bus is the packet's last
  logic                under_q, under_d;    // underrun abort still needs a drain
  logic [GAP_BITS-1:0] gap_q, gap_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                w_pid_ok;

  // PID check nibble must be the ones-complement of the PID nibble.
  assign w_pid_ok = (s_tdata[7:4] == ~s_tdata[3:0]);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    stp_d    = 1'b0;
    last_d   = last_q;
    under_d  = under_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    s_tready = 1'b0;

    case (state_q)
      S_IDLE: begin
        s_tready = s_tvalid && !ulpi_dir_i;
        if (s_tvalid && !ulpi_dir_i) begin
          if (w_pid_ok) begin
            data_d  = {4'b0100, s_tdata[3:0]};
            last_d  = s_tlast;
            state_d = S_SEND;
          end else begin
            err_d = 1'b1;
            if (s_tlast) begin
              gap_d   = C_GAP_LOAD;
              state_d = S_GAP;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end

      S_SEND: begin
        // DIR wins over NXT: the PHY has taken the bus, so no STP is driven.
        if (ulpi_dir_i) begin
          data_d = 8'h00;
          err_d  = 1'b1;
          if (last_q) begin
            gap_d   = C_GAP_LOAD;
            state_d = S_GAP;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (ulpi_nxt_i && last_q) begin
          data_d  = 8'h00;
          stp_d   = 1'b1;
          done_d  = 1'b1;
          under_d = 1'b0;
          state_d = S_STOP;
        end else if (ulpi_nxt_i && s_tvalid) begin
          s_tready = 1'b1;
          data_d   = s_tdata;
          last_d   = s_tlast;
        end else if (ulpi_nxt_i) begin
          // Underrun: STP with FFh forces a bit-stuff error so the host
          // discards the truncated packet.
          data_d  = 8'hFF;
          stp_d   = 1'b1;
          err_d   = 1'b1;
          under_d = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        data_d = 8'h00;
        if (under_q) begin
          under_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          gap_d   = C_GAP_LOAD;
          state_d = S_GAP;
        end
      end

      S_DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          gap_d   = C_GAP_LOAD;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        data_d  = 8'h00;
      end
    endcase

    // Nothing is accepted while reset is held.
    if (reset) begin
      s_tready = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= 8'h00;
      stp_q   <= 1'b0;
      last_q  <= 1'b0;
      under_q <= 1'b0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      stp_q   <= stp_d;
      last_q  <= last_d;
      under_q <= under_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ulpi_data_o = data_q;
  assign ulpi_stp_o  = stp_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire
